// File: rtl/lm75_temp_reader.sv
// Periodic I2C reader for an LM75-class sensor's temperature register.
// temp_data is replaced in a single cycle and flagged with a one-cycle temp_valid pulse.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | poll wait, bus released
// START    | start condition (SDA falls while SCL is high)
// ADDR     | 8 bit slots sending {DEV_ADDR, read}
// ADDR_ACK | release SDA and sample the slave ACK
// RD_MSB   | 8 bit slots receiving the MSB
// M_ACK    | master ACK (SDA held low)
// RD_LSB   | 8 bit slots receiving the LSB
// M_NACK   | master NACK (SDA released)
// STOP     | stop condition (SDA rises while SCL is high)
// DONE     | one cycle: publish the result, then return to IDLE
module lm75_temp_reader #(
    parameter int         CLK_DIV     = 125,
    parameter logic [6:0] DEV_ADDR    = 7'h48,
    parameter int         POLL_CYCLES = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        scl_oe,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        busy,
    output logic        ack_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_RD_MSB,
        S_M_ACK, S_RD_LSB, S_M_NACK, S_STOP, S_DONE
    } state_t;

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [7:0]    ADDR_BYTE = {DEV_ADDR, 1'b1};

    state_t        state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    ph_q, ph_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    msb_q, msb_d;
    logic          nack_q, nack_d;
    logic          sda_oe_q, sda_oe_d;
    logic          scl_oe_q, scl_oe_d;
    logic [15:0]   temp_data_q, temp_data_d;
    logic          temp_valid_q, temp_valid_d;
    logic          busy_q, busy_d;
    logic          ack_err_q, ack_err_d;

    logic tick, sample, slot_end, byte_state;

    assign tick       = (state_q != S_IDLE) && (div_q == DIV_LAST);
    assign sample     = tick && (ph_q == 2'd2);
    assign slot_end   = tick && (ph_q == 2'd3);
    assign byte_state = (state_q == S_ADDR) || (state_q == S_RD_MSB) || (state_q == S_RD_LSB);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (poll_q == POLL_LAST) state_d = S_START;
            S_START:    if (slot_end) state_d = S_ADDR;
            S_ADDR:     if (slot_end && bit_q == 3'd7) state_d = S_ADDR_ACK;
            S_ADDR_ACK: if (slot_end) state_d = nack_q ? S_STOP : S_RD_MSB;
            S_RD_MSB:   if (slot_end && bit_q == 3'd7) state_d = S_M_ACK;
            S_M_ACK:    if (slot_end) state_d = S_RD_LSB;
            S_RD_LSB:   if (slot_end && bit_q == 3'd7) state_d = S_M_NACK;
            S_M_NACK:   if (slot_end) state_d = S_STOP;
            S_STOP:     if (slot_end) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Line levels follow the current slot phase; the extra register stage keeps the pins glitch-free.
    always_comb begin
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b0;
        case (state_q)
            S_START: begin
                sda_oe_d = ph_q[1];
                scl_oe_d = (ph_q == 2'd3);
            end
            S_ADDR: begin
                sda_oe_d = ~ADDR_BYTE[3'd7 - bit_q];
                scl_oe_d = (ph_q == 2'd0) || (ph_q == 2'd3);
            end
            S_ADDR_ACK, S_RD_MSB, S_RD_LSB, S_M_NACK: begin
                scl_oe_d = (ph_q == 2'd0) || (ph_q == 2'd3);
            end
            S_M_ACK: begin
                sda_oe_d = 1'b1;
                scl_oe_d = (ph_q == 2'd0) || (ph_q == 2'd3);
            end
            S_STOP: begin
                sda_oe_d = (ph_q == 2'd0) || (ph_q == 2'd1);
                scl_oe_d = (ph_q == 2'd0);
            end
            default: begin
                sda_oe_d = 1'b0;
                scl_oe_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        poll_d       = '0;
        div_d        = '0;
        ph_d         = ph_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        msb_d        = msb_q;
        nack_d       = nack_q;
        temp_data_d  = temp_data_q;
        temp_valid_d = 1'b0;
        ack_err_d    = ack_err_q;
        busy_d       = (state_d != S_IDLE);

        if (state_q == S_IDLE) begin
            poll_d = (poll_q == POLL_LAST) ? '0 : poll_q + PW'(1);
            ph_d   = 2'd0;
            bit_d  = 3'd0;
            nack_d = 1'b0;
        end else if (state_q != S_DONE) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end

        if (tick) ph_d = ph_q + 2'd1;
        if (slot_end && byte_state) bit_d = bit_q + 3'd1;

        if (sample && (state_q == S_RD_MSB || state_q == S_RD_LSB))
            shift_d = {shift_q[6:0], sda_i};
        if (slot_end && state_q == S_RD_MSB && bit_q == 3'd7)
            msb_d = shift_q;

        if (sample && state_q == S_ADDR_ACK) begin
            nack_d = sda_i;
            if (sda_i) ack_err_d = 1'b1;
        end

        if (state_q == S_DONE && !nack_q) begin
            temp_data_d  = {msb_q, shift_q};
            temp_valid_d = 1'b1;
            ack_err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            poll_q       <= '0;
            div_q        <= '0;
            ph_q         <= 2'd0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            msb_q        <= 8'h00;
            nack_q       <= 1'b0;
            sda_oe_q     <= 1'b0;
            scl_oe_q     <= 1'b0;
            temp_data_q  <= 16'h0000;
            temp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            poll_q       <= poll_d;
            div_q        <= div_d;
            ph_q         <= ph_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            msb_q        <= msb_d;
            nack_q       <= nack_d;
            sda_oe_q     <= sda_oe_d;
            scl_oe_q     <= scl_oe_d;
            temp_data_q  <= temp_data_d;
            temp_valid_q <= temp_valid_d;
            busy_q       <= busy_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign scl_oe     = scl_oe_q;
    assign temp_data  = temp_data_q;
    assign temp_valid = temp_valid_q;
    assign busy       = busy_q;
    assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_lm75_temp_reader.sv
// Directed bench for lm75_temp_reader: open-drain bus with a small LM75 slave model.
module tb_lm75_temp_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sda_i;
    logic        sda_oe, scl_oe;
    logic [15:0] temp_data;
    logic        temp_valid, busy, ack_err;

    int n_vec  = 0;
    int n_miss = 0;

    lm75_temp_reader #(.CLK_DIV(4), .DEV_ADDR(7'h48), .POLL_CYCLES(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sda_i      (sda_i),
        .sda_oe     (sda_oe),
        .scl_oe     (scl_oe),
        .temp_data  (temp_data),
        .temp_valid (temp_valid),
        .busy       (busy),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;

    // slave behaviour, set from the stimulus process
    logic       s_ack;
    logic [7:0] s_msb, s_lsb;

    logic slave_pull = 1'b0;
    wire  scl_line = ~scl_oe;
    wire  sda_line = ~(sda_oe | slave_pull);
    assign sda_i = sda_line;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       scl_p = 1'b1, sda_p = 1'b1, busy_p = 1'b0, in_txn = 1'b0;
    int         clk_cnt = 0;
    int         busy_rise_cyc = 0, busy_fall_cyc = 0, valid_cyc = 0;
    int         valid_cnt = 0, start_cnt = 0, stop_cnt = 0;
    logic [7:0] addr_rx = 8'h00;
    logic       mack_sda = 1'b1, mnack_sda = 1'b0;

    function automatic logic pull_for(int n);
        if (n == 8) return s_ack;
        if (!s_ack) return 1'b0;
        if (n >= 9 && n <= 16) return ~s_msb[16 - n];
        if (n >= 18 && n <= 25) return ~s_lsb[25 - n];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        scl_p  <= scl_line;
        sda_p  <= sda_line;
        busy_p <= busy;
        if (busy && !busy_p) busy_rise_cyc <= cyc;
        if (!busy && busy_p) busy_fall_cyc <= cyc;
        if (temp_valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
        end
        if (!rst_n) begin
            in_txn     <= 1'b0;
            slave_pull <= 1'b0;
        end else if (scl_p && scl_line && sda_p && !sda_line) begin
            start_cnt  <= start_cnt + 1;
            in_txn     <= 1'b1;
            clk_cnt    <= -1;
            addr_rx    <= 8'h00;
            slave_pull <= 1'b0;
        end else if (scl_p && scl_line && !sda_p && sda_line) begin
            stop_cnt   <= stop_cnt + 1;
            in_txn     <= 1'b0;
            slave_pull <= 1'b0;
        end else if (in_txn && scl_p && !scl_line) begin
            clk_cnt    <= clk_cnt + 1;
            slave_pull <= pull_for(clk_cnt + 1);
        end else if (in_txn && !scl_p && scl_line) begin
            if (clk_cnt < 8)   addr_rx   <= {addr_rx[6:0], sda_line};
            if (clk_cnt == 17) mack_sda  <= sda_line;
            if (clk_cnt == 26) mnack_sda <= sda_line;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    int rel_cyc = 0;

    task automatic run_txn(input logic ack, input logic [7:0] m, input logic [7:0] l,
                           output int vcnt, output int scnt, output int pcnt);
        int v0, s0, p0;
        s_ack = ack;
        s_msb = m;
        s_lsb = l;
        v0 = valid_cnt;
        s0 = start_cnt;
        p0 = stop_cnt;
        for (int i = 0; i < 3000 && !busy; i++) @(negedge clk);
        check_vec("busy_rise", busy, 1);
        for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
        check_vec("busy_fall", busy, 0);
        repeat (3) @(negedge clk);
        vcnt = valid_cnt - v0;
        scnt = start_cnt - s0;
        pcnt = stop_cnt - p0;
    endtask

    int vc, sc, pc;

    initial begin
        rst_n = 1'b0;
        s_ack = 1'b1;
        s_msb = 8'h19;
        s_lsb = 8'h80;
        repeat (5) @(negedge clk);
        check_vec("rst_sda_oe", sda_oe, 0);
        check_vec("rst_scl_oe", scl_oe, 0);
        check_vec("rst_temp", temp_data, 16'h0000);
        check_vec("rst_valid", temp_valid, 0);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_ackerr", ack_err, 0);

        rst_n = 1'b1;
        rel_cyc = cyc;
        run_txn(1'b1, 8'h19, 8'h80, vc, sc, pc);
        check_vec("poll_latency", busy_rise_cyc - rel_cyc, 10);
        check_vec("valid_latency", valid_cyc - busy_rise_cyc, 465);
        check_vec("busy_len", busy_fall_cyc - busy_rise_cyc, 465);
        check_vec("valid_pulses", vc, 1);
        check_vec("temp_1980", temp_data, 16'h1980);
        check_vec("ackerr_ok", ack_err, 0);
        check_vec("addr_byte", addr_rx, 8'h91);
        check_vec("start_count", sc, 1);
        check_vec("stop_count", pc, 1);
        check_vec("master_ack", mack_sda, 0);
        check_vec("master_nack", mnack_sda, 1);

        run_txn(1'b0, 8'h55, 8'hAA, vc, sc, pc);
        check_vec("nack_ackerr", ack_err, 1);
        check_vec("nack_valid", vc, 0);
        check_vec("nack_hold", temp_data, 16'h1980);
        check_vec("nack_busy_len", busy_fall_cyc - busy_rise_cyc, 177);
        check_vec("nack_start", sc, 1);
        check_vec("nack_stop", pc, 1);

        run_txn(1'b1, 8'h1E, 8'h00, vc, sc, pc);
        check_vec("temp_1e00", temp_data, 16'h1E00);
        check_vec("ackerr_clear", ack_err, 0);
        check_vec("valid_1e00", vc, 1);

        run_txn(1'b1, 8'hFF, 8'h80, vc, sc, pc);
        check_vec("temp_ff80", temp_data, 16'hFF80);
        check_vec("valid_ff80", vc, 1);

        s_ack = 1'b1;
        s_msb = 8'h19;
        s_lsb = 8'h80;
        for (int i = 0; i < 3000 && !(in_txn && clk_cnt == 12); i++) @(negedge clk);
        check_vec("reach_rd_msb", clk_cnt, 12);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_vec("midrst_sda_oe", sda_oe, 0);
        check_vec("midrst_scl_oe", scl_oe, 0);
        check_vec("midrst_busy", busy, 0);
        check_vec("midrst_temp", temp_data, 16'h0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        run_txn(1'b1, 8'h19, 8'h80, vc, sc, pc);
        check_vec("restart_latency", busy_rise_cyc - rel_cyc, 10);
        check_vec("restart_temp", temp_data, 16'h1980);
        check_vec("restart_valid", vc, 1);
        check_vec("restart_addr", addr_rx, 8'h91);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/lm75_temp_reader.md
Name: lm75_temp_reader

Overview:
- I2C master that periodically reads the 16-bit temperature register of an LM75-class sensor and presents it as a parallel word to the character-LCD driver.
- Output format feeds the display directly:
  - temp_data[14:8] is the integer °C value.
  - temp_data[7] is the 0.5 °C bit.
  - temp_data[15] is the sign.
- Sits between the board I2C pins and the LCD stage. The LCD stage samples temp_data asynchronously to its own refresh, so temp_data only ever changes atomically.

Parameters:
- CLK_DIV, 125: clk cycles per quarter-bit tick. SCL period is 4*CLK_DIV cycles. Minimum legal value is 2.
- DEV_ADDR, 7'h48: 7-bit sensor address.
- POLL_CYCLES, 5000000: clk cycles spent in IDLE between transactions. Minimum legal value is 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sda_i  in  1  sampled SDA line level
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
- scl_oe  out  1  1 = pull SCL low; 0 = release
- temp_data  out  16  {MSB, LSB} of the last successful read
- temp_valid  out  1  one-cycle pulse when temp_data updates
- busy  out  1  high while a transaction is in progress
- ack_err  out  1  sticky; set when the address is NACKed; cleared by the next successful read

Behaviour:
- Reset values: sda_oe=0, scl_oe=0, temp_data=16'h0000, temp_valid=0, busy=0, ack_err=0, state=IDLE, all counters 0.
- Reset asserted mid-transaction releases both lines on the next clk edge. Bus recovery is out of scope.
- IDLE:
  - Poll counter increments each cycle.
  - At POLL_CYCLES-1: counter clears, state goes to START, busy goes high.
  - This also applies after reset, so the first read starts POLL_CYCLES cycles after rst_n rises.
- Tick divider:
  - Held at 0 in IDLE; otherwise counts 0..CLK_DIV-1.
  - Emits tick when the count reaches CLK_DIV-1.
  - Phase counter ph (0..3) advances on each tick. Every bit slot is 4 ticks.
- START slot:
  - ph0: both lines released.
  - ph1: hold.
  - ph2: sda_oe=1.
  - ph3: scl_oe=1.
- Data bit slot (write and read):
  - ph0: scl_oe=1; for writes, sda_oe=~bit; for reads, sda_oe=0.
  - ph1: scl_oe=0.
  - ph2: sample sda_i for reads and ACKs.
  - ph3: scl_oe=1.
  - Bits are sent and received MSB first.
- State sequence:
  - START
  - ADDR: 8 slots, byte {DEV_ADDR,1'b1}
  - ADDR_ACK: 1 slot, sda released. If sampled 1, set ack_err and go to STOP with no data update.
  - RD_MSB: 8 slots
  - M_ACK: 1 slot, sda_oe=1
  - RD_LSB: 8 slots
  - M_NACK: 1 slot, sda_oe=0
  - STOP
  - DONE
- No pointer write is performed; the sensor's power-on pointer (temperature register) is relied upon.
- STOP slot:
  - ph0: scl_oe=1, sda_oe=1.
  - ph1: scl_oe=0.
  - ph2: sda_oe=0.
  - ph3: hold.
- DONE (one clk cycle):
  - On success: temp_data <= {msb, lsb} loaded in a single cycle; temp_valid=1 for exactly that cycle; ack_err <= 0.
  - Then busy=0 and state goes to IDLE.
  - After a NACKed transaction, DONE leaves temp_data unchanged and does not pulse temp_valid.
- Latency: the full transaction is 29 slots = 116 ticks. temp_valid asserts 116*CLK_DIV+1 cycles after busy rises, counted from the cycle after the IDLE exit decision.
- The NACK path is 11 slots, i.e. 44*CLK_DIV+1 cycles to busy=0.
- Slave clock stretching is not supported; SCL is never sampled.
- sda_oe and scl_oe are registered and glitch-free. At most one of them changes per tick.
- Raw data is passed through unmodified. temp_data[6:0] carries whatever the sensor returns (nominally 0).

Test Plan:
- Reset then run, CLK_DIV=4, POLL_CYCLES=10; slave model ACKs and returns 8'h19, 8'h80:
  - busy rises 10 cycles after reset release.
  - temp_valid pulses once, 465 cycles later.
  - temp_data=16'h1980 (25.5 °C); ack_err=0.
- Address byte check:
  - Decode SDA on SCL rising edges during ADDR → 8'h91 observed.
  - START shows SDA falling while SCL is high; STOP shows SDA rising while SCL is high.
  - SDA never changes while SCL is released, except at START and STOP.
- Slave NACKs the address:
  - ack_err=1, no temp_valid, temp_data holds its previous value 16'h1980.
  - busy falls 177 cycles after rising.
  - Next successful read returning 8'h1E, 8'h00 gives temp_data=16'h1E00 and ack_err=0.
- Negative reading: slave returns 8'hFF, 8'h80 → temp_data=16'hFF80, temp_valid pulses.
- rst_n low during RD_MSB bit 3:
  - Next edge: sda_oe=0, scl_oe=0, busy=0, temp_data=0.
  - After release, a clean transaction restarts after POLL_CYCLES.
- Master ACK/NACK: observe SDA low during the ninth clock after the MSB and released (high) during the ninth clock after the LSB.
